// File: rtl/fetch_sequencer.sv
// IF-stage control for the RV32I pipeline: owns the PC, next-PC selection,
// program-load phase, IF/ID enable/flush, fetch counter and stall watchdog.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          LOAD_ENABLE = 1'b1,
  parameter int unsigned MAX_STALL   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic [31:0] imem_raddr,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic [31:0] fetch_count,
  output logic [1:0]  state,
  output logic [1:0]  err
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'b00,
    S_RUN   = 2'b01,
    S_STALL = 2'b10,
    S_HALT  = 2'b11
  } state_e;

  localparam logic [7:0] MAX_STALL_W = 8'(MAX_STALL);
  localparam state_e     START_STATE = LOAD_ENABLE ? S_LOAD : S_RUN;

  state_e      cur_state, next_state;
  logic [31:0] pc_q, pc_next;
  logic [31:0] fc_q, fc_next;
  logic [1:0]  err_q, err_next;
  logic [7:0]  stall_cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_state <= START_STATE;
      pc_q      <= RESET_PC;
      fc_q      <= '0;
      err_q     <= '0;
      stall_cnt <= '0;
    end else begin
      cur_state <= next_state;
      pc_q      <= pc_next;
      fc_q      <= fc_next;
      err_q     <= err_next;
      stall_cnt <= cnt_next;
    end
  end

  always_comb begin
    next_state = cur_state;
    pc_next    = pc_q;
    fc_next    = fc_q;
    err_next   = err_q;
    cnt_next   = stall_cnt;
    imem_we    = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;

    unique case (cur_state)
      S_LOAD: begin
        if (load_valid) begin
          // A misaligned word is still consumed so the loader never wedges.
          if (load_addr[1:0] != 2'b00) err_next[0] = 1'b1;
          else                         imem_we     = 1'b1;
          if (load_last) begin
            next_state = S_RUN;
            pc_next    = RESET_PC;
          end
        end
      end

      // STALL shares RUN priorities so a stall release steps in the same cycle.
      S_RUN, S_STALL: begin
        if (redirect_valid) begin
          ifid_flush = 1'b1;
          cnt_next   = '0;
          if (redirect_target[1:0] != 2'b00) begin
            err_next[0] = 1'b1;
            next_state  = S_HALT;
          end else begin
            ifid_en    = 1'b1;
            pc_next    = redirect_target;
            next_state = S_RUN;
          end
        end else if (stall_in) begin
          cnt_next = (cur_state == S_STALL) ? stall_cnt + 8'd1 : 8'd1;
          if (cnt_next >= MAX_STALL_W) begin
            err_next[1] = 1'b1;
            next_state  = S_HALT;
          end else begin
            next_state = S_STALL;
          end
        end else if (halt_req) begin
          cnt_next   = '0;
          next_state = S_HALT;
        end else begin
          ifid_en    = 1'b1;
          pc_next    = pc_q + 32'd4;
          fc_next    = fc_q + 32'd1;
          cnt_next   = '0;
          next_state = S_RUN;
        end
      end

      S_HALT: begin
        if (resume) begin
          cnt_next   = '0;
          next_state = S_RUN;
        end
      end

      default: next_state = START_STATE;
    endcase
  end

  assign load_ready  = (cur_state == S_LOAD);
  assign imem_waddr  = load_addr;
  assign imem_wdata  = load_data;
  assign imem_raddr  = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign fetch_count = fc_q;
  assign state       = cur_state;
  assign err         = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: load, step, redirect, stall,
// watchdog, halt/resume and reset scenarios with hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_last;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] imem_raddr;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        ifid_en;
  logic        ifid_flush;
  logic [31:0] fetch_count;
  logic [1:0]  state;
  logic [1:0]  err;

  int checks;
  int errors;

  fetch_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .LOAD_ENABLE (1'b1),
    .MAX_STALL   (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_last       (load_last),
    .imem_we         (imem_we),
    .imem_waddr      (imem_waddr),
    .imem_wdata      (imem_wdata),
    .imem_raddr      (imem_raddr),
    .stall_in        (stall_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .fetch_count     (fetch_count),
    .state           (state),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks += 5;
    if (state !== 2'b00)   begin errors++; $display("FAIL reset_state: got %b expected 00", state); end
    if (pc !== 32'h0)      begin errors++; $display("FAIL reset_pc: got %h expected 00000000", pc); end
    if (err !== 2'b00)     begin errors++; $display("FAIL reset_err: got %b expected 00", err); end
    if (fetch_count !== 0) begin errors++; $display("FAIL reset_fc: got %0d expected 0", fetch_count); end
    if (load_ready !== 1'b1 || ifid_en !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl: got ready=%b en=%b expected ready=1 en=0", load_ready, ifid_en); end
  endtask

  task automatic test_load();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    logic [31:0] exp_pc;
    addrs = '{32'h0, 32'h4, 32'h8};
    datas = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_addr  = addrs[i];
      load_data  = datas[i];
      load_last  = (i == 2);
      #1;
      checks += 1;
      if (imem_we !== 1'b1 || imem_waddr !== addrs[i] || imem_wdata !== datas[i])
        begin errors++; $display("FAIL load_write%0d: got we=%b a=%h d=%h expected we=1 a=%h d=%h",
                                 i, imem_we, imem_waddr, imem_wdata, addrs[i], datas[i]); end
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    checks += 2;
    if (state !== 2'b01) begin errors++; $display("FAIL load_done_state: got %b expected 01", state); end
    if (pc !== 32'h0 || imem_raddr !== 32'h0 || pc_plus4 !== 32'h4)
      begin errors++; $display("FAIL load_done_pc: got pc=%h raddr=%h p4=%h expected 0/0/4", pc, imem_raddr, pc_plus4); end
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks += 1;
      if (ifid_en !== 1'b1 || ifid_flush !== 1'b0)
        begin errors++; $display("FAIL step_ctrl%0d: got en=%b fl=%b expected en=1 fl=0", i, ifid_en, ifid_flush); end
      tick();
      exp_pc = exp_pc + 32'd4;
      checks += 1;
      if (pc !== exp_pc) begin errors++; $display("FAIL step_pc%0d: got %h expected %h", i, pc, exp_pc); end
    end
    checks += 1;
    if (fetch_count !== 3) begin errors++; $display("FAIL step_fc: got %0d expected 3", fetch_count); end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 4; i++) tick();
    checks += 2;
    if (pc !== 32'h1C)     begin errors++; $display("FAIL pre_redirect_pc: got %h expected 0000001c", pc); end
    if (fetch_count !== 7) begin errors++; $display("FAIL pre_redirect_fc: got %0d expected 7", fetch_count); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h3C;
    #1;
    checks += 1;
    if (ifid_flush !== 1'b1 || ifid_en !== 1'b1)
      begin errors++; $display("FAIL redirect_ctrl: got fl=%b en=%b expected fl=1 en=1", ifid_flush, ifid_en); end
    tick();
    redirect_valid = 1'b0;
    checks += 3;
    if (pc !== 32'h3C)     begin errors++; $display("FAIL redirect_pc: got %h expected 0000003c", pc); end
    if (fetch_count !== 7) begin errors++; $display("FAIL redirect_fc: got %0d expected 7", fetch_count); end
    if (state !== 2'b01)   begin errors++; $display("FAIL redirect_state: got %b expected 01", state); end
  endtask

  task automatic test_stall();
    redirect_valid  = 1'b1;
    redirect_target = 32'h2C;
    tick();
    redirect_valid = 1'b0;
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks += 1;
      if (ifid_en !== 1'b0) begin errors++; $display("FAIL stall_en%0d: got %b expected 0", i, ifid_en); end
      tick();
      checks += 1;
      if (state !== 2'b10 || pc !== 32'h2C)
        begin errors++; $display("FAIL stall_hold%0d: got st=%b pc=%h expected st=10 pc=0000002c", i, state, pc); end
    end
    stall_in = 1'b0;
    #1;
    checks += 1;
    if (ifid_en !== 1'b1) begin errors++; $display("FAIL stall_exit_en: got %b expected 1", ifid_en); end
    tick();
    checks += 2;
    if (state !== 2'b01 || pc !== 32'h30)
      begin errors++; $display("FAIL stall_exit: got st=%b pc=%h expected st=01 pc=00000030", state, pc); end
    if (fetch_count !== 8) begin errors++; $display("FAIL stall_exit_fc: got %0d expected 8", fetch_count); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h80;
    stall_in        = 1'b1;
    tick();
    redirect_valid = 1'b0;
    checks += 1;
    if (state !== 2'b01 || pc !== 32'h80)
      begin errors++; $display("FAIL redirect_over_stall: got st=%b pc=%h expected st=01 pc=00000080", state, pc); end
    tick();
    checks += 1;
    if (state !== 2'b10) begin errors++; $display("FAIL stall_again: got %b expected 10", state); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    stall_in       = 1'b0;
    checks += 2;
    if (state !== 2'b01 || pc !== 32'h100)
      begin errors++; $display("FAIL redirect_in_stall: got st=%b pc=%h expected st=01 pc=00000100", state, pc); end
    if (fetch_count !== 8) begin errors++; $display("FAIL redirect_in_stall_fc: got %0d expected 8", fetch_count); end
  endtask

  task automatic test_halt();
    halt_req        = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    tick();
    redirect_valid = 1'b0;
    checks += 1;
    if (state !== 2'b01 || pc !== 32'h200)
      begin errors++; $display("FAIL halt_wrongpath: got st=%b pc=%h expected st=01 pc=00000200", state, pc); end
    #1;
    checks += 1;
    if (ifid_en !== 1'b0) begin errors++; $display("FAIL halt_req_en: got %b expected 0", ifid_en); end
    tick();
    halt_req = 1'b0;
    tick();
    checks += 2;
    if (state !== 2'b11 || pc !== 32'h200)
      begin errors++; $display("FAIL halt_frozen: got st=%b pc=%h expected st=11 pc=00000200", state, pc); end
    if (ifid_en !== 1'b0 || imem_we !== 1'b0 || fetch_count !== 8)
      begin errors++; $display("FAIL halt_ctrl: got en=%b we=%b fc=%0d expected 0/0/8", ifid_en, imem_we, fetch_count); end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks += 1;
    if (state !== 2'b01 || pc !== 32'h200)
      begin errors++; $display("FAIL resume: got st=%b pc=%h expected st=01 pc=00000200", state, pc); end
    tick();
    checks += 1;
    if (pc !== 32'h204) begin errors++; $display("FAIL resume_step: got %h expected 00000204", pc); end
  endtask

  task automatic test_watchdog();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks += 1;
    if (state !== 2'b10) begin errors++; $display("FAIL wd_before: got %b expected 10", state); end
    tick();
    checks += 2;
    if (state !== 2'b11 || pc !== 32'h204)
      begin errors++; $display("FAIL wd_halt: got st=%b pc=%h expected st=11 pc=00000204", state, pc); end
    if (err !== 2'b10) begin errors++; $display("FAIL wd_err: got %b expected 10", err); end
    stall_in = 1'b0;
    resume   = 1'b1;
    tick();
    resume = 1'b0;
    checks += 1;
    if (state !== 2'b01 || pc !== 32'h204)
      begin errors++; $display("FAIL wd_resume: got st=%b pc=%h expected st=01 pc=00000204", state, pc); end
    tick();
    checks += 2;
    if (pc !== 32'h208) begin errors++; $display("FAIL wd_step: got %h expected 00000208", pc); end
    if (err !== 2'b10)  begin errors++; $display("FAIL wd_sticky: got %b expected 10", err); end
  endtask

  task automatic test_reset_in_halt();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks += 1;
    if (state !== 2'b11) begin errors++; $display("FAIL pre_reset_halt: got %b expected 11", state); end
    do_reset();
    checks += 2;
    if (state !== 2'b00 || pc !== 32'h0 || err !== 2'b00)
      begin errors++; $display("FAIL reset_in_halt: got st=%b pc=%h err=%b expected 00/0/00", state, pc, err); end
    if (fetch_count !== 0) begin errors++; $display("FAIL reset_in_halt_fc: got %0d expected 0", fetch_count); end
  endtask

  task automatic test_misaligned_load();
    logic [31:0] addrs [3];
    logic [2:0]  exp_we;
    addrs  = '{32'h0, 32'h6, 32'h8};
    exp_we = 3'b101;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_addr  = addrs[i];
      load_data  = 32'hABCD_0000 + 32'(i);
      load_last  = (i == 2);
      #1;
      checks += 1;
      if (imem_we !== exp_we[i] || load_ready !== 1'b1)
        begin errors++; $display("FAIL misload_we%0d: got we=%b rdy=%b expected we=%b rdy=1", i, imem_we, load_ready, exp_we[i]); end
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    checks += 2;
    if (err !== 2'b01) begin errors++; $display("FAIL misload_err: got %b expected 01", err); end
    if (state !== 2'b01 || pc !== 32'h0)
      begin errors++; $display("FAIL misload_done: got st=%b pc=%h expected st=01 pc=00000000", state, pc); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    load_valid = 1'b1;
    load_addr  = 32'h0;
    load_data  = 32'h1234_5678;
    load_last  = 1'b0;
    tick();
    load_valid = 1'b0;
    do_reset();
    checks += 1;
    if (state !== 2'b00 || load_ready !== 1'b1 || pc !== 32'h0)
      begin errors++; $display("FAIL reset_mid_load: got st=%b rdy=%b pc=%h expected 00/1/0", state, load_ready, pc); end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b0;
    load_valid      = 1'b0;
    load_addr       = '0;
    load_data       = '0;
    load_last       = 1'b0;
    stall_in        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    halt_req        = 1'b0;
    resume          = 1'b0;
    test_reset();
    test_load();
    test_redirect();
    test_stall();
    test_halt();
    test_watchdog();
    test_reset_in_halt();
    test_misaligned_load();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control block for the IF stage of the 5-stage RV32I pipeline. It owns the PC register and the next-PC selection: sequential step, branch/jump redirect, load-use stall, halt/resume.
- After reset it runs a program-load phase, during which a valid/ready loader writes the instruction memory. Fetch starts only after the loader signals the last word.
- It drives the instruction-memory read address and the IF/ID enable/flush controls, and keeps a fetch counter and a stall watchdog.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset and after load completes.
- LOAD_ENABLE, 1, 1: start in LOAD after reset; 0: start directly in RUN.
- MAX_STALL, 16, maximum consecutive stall cycles before watchdog halt (range 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- load_valid  in  1  loader word valid
- load_ready  out  1  block accepts loader word
- load_addr  in  32  byte address of loader word
- load_data  in  32  instruction word
- load_last  in  1  final loader word
- imem_we  out  1  instruction-memory write enable
- imem_waddr  out  32  write byte address
- imem_wdata  out  32  write data
- imem_raddr  out  32  read address (= pc)
- stall_in  in  1  load-use stall from hazard unit (level)
- redirect_valid  in  1  branch taken / jump resolved in EX (pulse)
- redirect_target  in  32  redirect byte address
- halt_req  in  1  halt request from decode (pulse)
- resume  in  1  leave HALT (pulse)
- pc  out  32  current fetch PC
- pc_plus4  out  32  pc + 4
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  clear IF/ID (insert bubble)
- fetch_count  out  32  count of instructions passed to IF/ID
- state  out  2  00 LOAD, 01 RUN, 10 STALL, 11 HALT
- err  out  2  sticky: bit0 misaligned address, bit1 stall watchdog

Behaviour:
- rst is synchronous and active-low; clock is clk. When rst=0 at a posedge, the following are set:
  - state = LOAD if LOAD_ENABLE, else RUN
  - pc = RESET_PC, fetch_count = 0, err = 0, stall counter = 0
- Outputs decoded from state and inputs:
  - load_ready = (state==LOAD); ifid_en = 0 and ifid_flush = 0 whenever state is not RUN/STALL.
  - imem_raddr = pc; pc_plus4 = pc+4 (32-bit, wraps).
- LOAD state:
  - On load_valid & load_ready, in the same cycle: imem_we=1, imem_waddr=load_addr, imem_wdata=load_data.
  - If load_addr[1:0]!=0, the write is suppressed (imem_we=0) and err[0] is set; the word still counts as accepted.
  - Accepted word with load_last=1: next state RUN, pc=RESET_PC.
  - load_valid=0: stay in LOAD.
- RUN state, priority redirect > stall > halt_req > step:
  - redirect_valid (cycle N): ifid_flush=1 and ifid_en=1 at N; pc=redirect_target at N+1. A halt_req or stall_in in the same cycle is ignored because it is wrong-path.
  - redirect_target[1:0]!=0: err[0] set, pc unchanged, next state HALT, ifid_flush=1.
  - stall_in=1: pc holds, ifid_en=0, next state STALL, stall counter=1.
  - halt_req=1: pc holds, ifid_en=0, next state HALT.
  - Otherwise: pc=pc+4, ifid_en=1, fetch_count+1 (wraps).
- STALL state:
  - pc holds and ifid_en=0 while stall_in=1; the stall counter increments each cycle.
  - stall_in=0: return to RUN and behave as a RUN cycle (step) in that same cycle.
  - redirect_valid in STALL: handled as in RUN, next state RUN.
  - Counter reaches MAX_STALL while stall_in is still 1: err[1] set, next state HALT.
- HALT state:
  - pc frozen; ifid_en=0 and imem_we=0.
  - resume=1: next state RUN, pc unchanged, stall counter cleared. err stays sticky until reset.
- fetch_count increments only on a RUN step or a RUN/STALL-exit step, never on redirect cycles.
- Reset mid-LOAD or mid-STALL: the next cycle is the reset state above; the partial load is abandoned, and memory contents already written are not cleared.

Test Plan:
- Reset then load 3 words (addr 0,4,8; last on addr 8) -> imem_we pulses 3 times with matching addr/data; state goes 00→01; pc=0, then 4, 8, C on consecutive cycles; fetch_count=3 after 3 steps.
- Load with addr 0x6 -> imem_we=0 for that word, err=01, load still completes on load_last.
- RUN at pc=0x1C, redirect_valid with target 0x3C -> ifid_flush=1 that cycle; pc=0x3C next cycle; fetch_count unchanged on the redirect cycle.
- stall_in high 2 cycles at pc=0x2C -> pc stays 0x2C, ifid_en=0 for 2 cycles, state 10; then pc=0x30. Same-cycle redirect+stall -> redirect wins, state 01.
- stall_in held high with MAX_STALL=4 -> after 4 stall cycles state=11, err=10; resume -> state 01 and pc advances.
- halt_req together with redirect_valid -> halt ignored, pc=target. Later halt_req alone -> state 11, pc frozen. rst=0 during HALT -> state 00, pc=0, err=00.
